// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard unit inputs from the
// pipeline and stall/flush controls back to it.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFID_Rs;
  logic [4:0]       IFID_Rt;
  logic             IFID_UsesRt;
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic             EX_BranchTaken;
  logic             MemBusy;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             Freeze;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;
  logic [CNT_W-1:0] FreezeCycles;
  logic             Timeout;
  logic [1:0]       State;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt,
    output IDEX_MemRead, IDEX_Rt,
    output EX_BranchTaken, MemBusy,
    input  PCWrite, IFIDWrite, IDEX_Bubble,
    input  IFID_Flush, Freeze,
    input  StallCycles, FlushCount,
    input  FreezeCycles, Timeout, State
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt,
    input  IDEX_MemRead, IDEX_Rt,
    input  EX_BranchTaken, MemBusy,
    output PCWrite, IFIDWrite, IDEX_Bubble,
    output IFID_Flush, Freeze,
    output StallCycles, FlushCount,
    output FreezeCycles, Timeout, State
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and
// memory-wait freeze control with stats/watchdog.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_M1 = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] TO_MX = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;
  logic            timeout;

  logic lu;
  logic c_freeze;
  logic c_flush;
  logic c_stall;

  assign lu = bus.IDEX_MemRead
           && (bus.IDEX_Rt != 5'd0)
           && ((bus.IDEX_Rt == bus.IFID_Rs)
            || (bus.IFID_UsesRt
             && bus.IDEX_Rt == bus.IFID_Rt));

  assign c_freeze = !rst && bus.MemBusy;
  assign c_flush  = !rst && !bus.MemBusy
                 && bus.EX_BranchTaken;
  assign c_stall  = !rst && !bus.MemBusy
                 && !bus.EX_BranchTaken
                 && lu && (state != LU_HOLD);

  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IFIDWrite   = 1'b1;
    bus.IDEX_Bubble = 1'b0;
    bus.IFID_Flush  = 1'b0;
    bus.Freeze      = 1'b0;
    priority case (1'b1)
      rst: begin
        bus.PCWrite     = 1'b0;
        bus.IFIDWrite   = 1'b0;
        bus.IDEX_Bubble = 1'b1;
        bus.IFID_Flush  = 1'b1;
      end
      c_freeze: begin
        bus.PCWrite   = 1'b0;
        bus.IFIDWrite = 1'b0;
        bus.Freeze    = 1'b1;
      end
      c_flush: begin
        bus.IDEX_Bubble = 1'b1;
        bus.IFID_Flush  = 1'b1;
      end
      c_stall: begin
        bus.PCWrite     = 1'b0;
        bus.IFIDWrite   = 1'b0;
        bus.IDEX_Bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        RUN:
          if (bus.MemBusy) state <= MEM_WAIT;
          else if (c_stall) state <= LU_HOLD;
          else state <= RUN;
        LU_HOLD:
          state <= bus.MemBusy ? MEM_WAIT : RUN;
        MEM_WAIT:
          state <= bus.MemBusy ? MEM_WAIT : RUN;
        default:
          state <= RUN;
      endcase
      // wait counter saturates so a long stall never re-arms
      if (!bus.MemBusy) wait_cnt <= '0;
      else if (wait_cnt != TO_MX)
        wait_cnt <= wait_cnt + 1'b1;
      if (bus.MemBusy && wait_cnt == TO_M1)
        timeout <= 1'b1;
      if (c_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (c_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
      if (c_freeze && freeze_cnt != '1)
        freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

  assign bus.State        = state;
  assign bus.StallCycles  = stall_cnt;
  assign bus.FlushCount   = flush_cnt;
  assign bus.FreezeCycles = freeze_cnt;
  assign bus.Timeout      = timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random stimulus against
// a history-based reference model of the hazard rules.
module tb_hazard_ctrl;
  localparam int CW = 3;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(
    .CNT_W(CW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_state;
  int m_stall;
  int m_flush;
  int m_freeze;
  int m_run;
  bit m_to;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_clear();
    m_state  = 0;
    m_stall  = 0;
    m_flush  = 0;
    m_freeze = 0;
    m_run    = 0;
    m_to     = 0;
  endtask

  task automatic step(input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic       ur,
                      input logic       mr,
                      input logic [4:0] xrt,
                      input logic       br,
                      input logic       busy,
                      input logic       r);
    bit lu;
    int kind;
    logic [4:0] exp_ctl;
    bus.IFID_Rs        = rs;
    bus.IFID_Rt        = rt;
    bus.IFID_UsesRt    = ur;
    bus.IDEX_MemRead   = mr;
    bus.IDEX_Rt        = xrt;
    bus.EX_BranchTaken = br;
    bus.MemBusy        = busy;
    rst                = r;
    #1;
    lu = mr && xrt != 0
      && (xrt == rs || (ur && xrt == rt));
    if (r)                        kind = 1;
    else if (busy)                kind = 2;
    else if (br)                  kind = 3;
    else if (lu && m_state != 1)  kind = 4;
    else                          kind = 5;
    // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Freeze}
    case (kind)
      1: exp_ctl = 5'b00110;
      2: exp_ctl = 5'b00001;
      3: exp_ctl = 5'b11110;
      4: exp_ctl = 5'b00100;
      default: exp_ctl = 5'b11000;
    endcase
    chk("ctl", {bus.PCWrite, bus.IFIDWrite,
                bus.IDEX_Bubble, bus.IFID_Flush,
                bus.Freeze}, exp_ctl);
    chk("state", bus.State, m_state);
    chk("stall", bus.StallCycles, m_stall);
    chk("flush", bus.FlushCount, m_flush);
    chk("freeze", bus.FreezeCycles, m_freeze);
    chk("timeout", bus.Timeout, m_to);
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      if (kind == 2) m_freeze = sat(m_freeze);
      if (kind == 3) m_flush  = sat(m_flush);
      if (kind == 4) m_stall  = sat(m_stall);
      m_run = busy ? m_run + 1 : 0;
      if (m_run == TO) m_to = 1;
      if (busy)                          m_state = 2;
      else if (kind == 4 && m_state == 0) m_state = 1;
      else                               m_state = 0;
    end
    #1;
  endtask

  task automatic idle(input logic busy,
                      input logic br);
    step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0,
         br, busy, 1'b0);
  endtask

  initial begin
    int burst;
    logic busy, br, r, ur, mr;
    logic [4:0] rs, rt, xrt;

    rst = 1'b1;
    bus.IFID_Rs = '0;
    bus.IFID_Rt = '0;
    bus.IFID_UsesRt = 1'b0;
    bus.IDEX_MemRead = 1'b0;
    bus.IDEX_Rt = '0;
    bus.EX_BranchTaken = 1'b0;
    bus.MemBusy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // lw $2 ; add $3,$2,$4 : one bubble, then held
    step(5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    step(5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // load to $0, and rt match without UsesRt
    step(5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step(5'd6, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);

    // branch with LU: flush only
    step(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // busy 5 cycles over a taken branch, then flush
    repeat (5) idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);

    // watchdog: busy 6 cycles, sticky after
    repeat (6) idle(1'b1, 1'b0);
    repeat (3) idle(1'b0, 1'b0);

    // saturate stall count, then reset mid-stall
    repeat (9) begin
      step(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
    end
    step(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else if ($urandom % 8 == 0) begin
        busy = 1'b1;
        burst = $urandom_range(0, 6);
      end else begin
        busy = 1'b0;
      end
      br  = ($urandom % 6 == 0);
      r   = ($urandom % 64 == 0);
      ur  = $urandom % 2;
      mr  = ($urandom % 3 != 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      xrt = 5'($urandom_range(0, 3));
      step(rs, rt, ur, mr, xrt, br, busy, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
